// File: rtl/dnn_layer_sched_if.sv
// Scheduler-to-MAC link: weight ROM strobe/bank select, MAC operands and MAC results.
interface dnn_layer_sched_if #(
    parameter int IN_SIZE  = 7,
    parameter int OUT_SIZE = 17
);
    logic                       w_rd_en;
    logic                       w_sel;
    logic signed [IN_SIZE-1:0]  mac_x0;
    logic signed [IN_SIZE-1:0]  mac_x1;
    logic signed [IN_SIZE-1:0]  mac_x2;
    logic signed [IN_SIZE-1:0]  mac_x3;
    logic                       mac_in_ready;
    logic                       mac_ready;
    logic signed [OUT_SIZE-1:0] mac_out0;
    logic signed [OUT_SIZE-1:0] mac_out1;
    logic signed [OUT_SIZE-1:0] mac_out2;
    logic signed [OUT_SIZE-1:0] mac_out3;

    modport master (
        output w_rd_en, w_sel, mac_x0, mac_x1, mac_x2, mac_x3, mac_in_ready,
        input  mac_ready, mac_out0, mac_out1, mac_out2, mac_out3
    );

    modport slave (
        input  w_rd_en, w_sel, mac_x0, mac_x1, mac_x2, mac_x3, mac_in_ready,
        output mac_ready, mac_out0, mac_out1, mac_out2, mac_out3
    );
endinterface

// File: rtl/dnn_layer_sched.sv
// Two-layer inference sequencer around a shared 4x4 MAC: fetch weights, issue, wait
// (with timeout), requantize layer-1 results with ReLU+clamp, then run layer 2.
module dnn_layer_sched #(
    parameter int IN_SIZE  = 7,
    parameter int OUT_SIZE = 17,
    parameter int SHIFT    = 5,
    parameter int TIMEOUT  = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic signed [IN_SIZE-1:0]  x0,
    input  logic signed [IN_SIZE-1:0]  x1,
    input  logic signed [IN_SIZE-1:0]  x2,
    input  logic signed [IN_SIZE-1:0]  x3,
    dnn_layer_sched_if.master          mac,
    output logic signed [OUT_SIZE-1:0] y0,
    output logic signed [OUT_SIZE-1:0] y1,
    output logic signed [OUT_SIZE-1:0] y2,
    output logic signed [OUT_SIZE-1:0] y3,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
    localparam logic signed [OUT_SIZE-1:0] QMAX = OUT_SIZE'((1 << (IN_SIZE - 1)) - 1);

    typedef enum logic [3:0] {
        StIdle, StFetch1, StIssue1, StWait1, StQuant,
        StFetch2, StIssue2, StWait2, StDone, StErr
    } state_e;

    state_e                     state_q;
    logic [CW-1:0]              cnt_q;
    logic                       w_rd_en_q, w_sel_q, mac_in_ready_q;
    logic                       busy_q, done_q, err_q;
    logic signed [IN_SIZE-1:0]  h_q  [4];
    logic signed [OUT_SIZE-1:0] l1_q [4];
    logic signed [OUT_SIZE-1:0] y_q  [4];

    logic signed [IN_SIZE-1:0]  x_in  [4];
    logic signed [OUT_SIZE-1:0] mo    [4];
    logic signed [OUT_SIZE-1:0] shr   [4];
    logic signed [IN_SIZE-1:0]  quant [4];

    assign x_in[0] = x0;
    assign x_in[1] = x1;
    assign x_in[2] = x2;
    assign x_in[3] = x3;
    assign mo[0]   = mac.mac_out0;
    assign mo[1]   = mac.mac_out1;
    assign mo[2]   = mac.mac_out2;
    assign mo[3]   = mac.mac_out3;

    // ReLU, arithmetic shift, then saturate to the largest positive activation
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            shr[i] = l1_q[i] >>> SHIFT;
            if (l1_q[i][OUT_SIZE-1]) begin
                quant[i] = '0;
            end else if (shr[i] > QMAX) begin
                quant[i] = QMAX[IN_SIZE-1:0];
            end else begin
                quant[i] = shr[i][IN_SIZE-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            w_rd_en_q      <= 1'b0;
            w_sel_q        <= 1'b0;
            mac_in_ready_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                h_q[i]  <= '0;
                l1_q[i] <= '0;
                y_q[i]  <= '0;
            end
        end else begin
            w_rd_en_q      <= 1'b0;
            mac_in_ready_q <= 1'b0;
            done_q         <= 1'b0;
            case (state_q)
                StIdle, StErr: begin
                    if (start) begin
                        for (int i = 0; i < 4; i++) h_q[i] <= x_in[i];
                        w_rd_en_q <= 1'b1;
                        w_sel_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                        state_q   <= StFetch1;
                    end
                end
                StFetch1: begin
                    mac_in_ready_q <= 1'b1;
                    state_q        <= StIssue1;
                end
                StIssue1: begin
                    cnt_q   <= '0;
                    state_q <= StWait1;
                end
                StWait1, StWait2: begin
                    // A result arriving on the timeout cycle still counts
                    if (mac.mac_ready) begin
                        if (state_q == StWait1) begin
                            for (int i = 0; i < 4; i++) l1_q[i] <= mo[i];
                            state_q <= StQuant;
                        end else begin
                            for (int i = 0; i < 4; i++) y_q[i] <= mo[i];
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end else if (cnt_q == TMO) begin
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= StErr;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StQuant: begin
                    h_q       <= quant;
                    w_rd_en_q <= 1'b1;
                    w_sel_q   <= 1'b1;
                    state_q   <= StFetch2;
                end
                StFetch2: begin
                    mac_in_ready_q <= 1'b1;
                    state_q        <= StIssue2;
                end
                StIssue2: begin
                    cnt_q   <= '0;
                    state_q <= StWait2;
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mac.w_rd_en      = w_rd_en_q;
    assign mac.w_sel        = w_sel_q;
    assign mac.mac_in_ready = mac_in_ready_q;
    assign mac.mac_x0       = h_q[0];
    assign mac.mac_x1       = h_q[1];
    assign mac.mac_x2       = h_q[2];
    assign mac.mac_x3       = h_q[3];
    assign y0               = y_q[0];
    assign y1               = y_q[1];
    assign y2               = y_q[2];
    assign y3               = y_q[3];
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;
endmodule

// File: tb/tb_dnn_layer_sched.sv
// Self-checking bench for dnn_layer_sched: directed vector table plus randomized runs
// checked against a cycle-count/arithmetic reference model with an emulated MAC.
module tb_dnn_layer_sched;
    localparam int IN     = 7;
    localparam int OUT    = 17;
    localparam int SH     = 5;
    localparam int TMO    = 15;
    localparam int QMAXI  = 2 ** (IN - 1) - 1;
    localparam int BUDGET = 45;

    typedef logic [3:0][31:0] q4_t;
    typedef struct packed {
        q4_t         x;
        q4_t         l1;
        q4_t         l2;
        int          d1;
        int          d2;
        int          stray;
        int          rstc;
        logic [31:0] smask;
        int          exp_end;
        logic        exp_err;
        q4_t         exp_h;
        q4_t         exp_y;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start;
    logic signed [IN-1:0]  x0, x1, x2, x3;
    logic signed [OUT-1:0] y0, y1, y2, y3;
    logic busy, done, err;
    int n_chk = 0;
    int n_fail = 0;
    q4_t model_y;

    dnn_layer_sched_if #(.IN_SIZE(IN), .OUT_SIZE(OUT)) mif ();

    dnn_layer_sched #(.IN_SIZE(IN), .OUT_SIZE(OUT), .SHIFT(SH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .mac(mif),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic q4_t mk4(input int a, input int b, input int c, input int d);
        q4_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    function automatic vec_t mkv(input q4_t x, input q4_t l1, input q4_t l2, input int d1,
                                 input int d2, input int stray, input int rstc,
                                 input logic [31:0] smask, input int exp_end,
                                 input logic exp_err, input q4_t exp_h, input q4_t exp_y);
        vec_t v;
        v.x = x; v.l1 = l1; v.l2 = l2; v.d1 = d1; v.d2 = d2; v.stray = stray;
        v.rstc = rstc; v.smask = smask; v.exp_end = exp_end; v.exp_err = exp_err;
        v.exp_h = exp_h; v.exp_y = exp_y;
        return v;
    endfunction

    // Reference requantizer: ReLU, floor-divide by 2^SHIFT, saturate
    function automatic int qref(input int r);
        if (r < 0) return 0;
        if (r / (2 ** SH) > QMAXI) return QMAXI;
        return r / (2 ** SH);
    endfunction

    // Reference timing: issue1 at cycle 2, MAC answers d cycles after each issue,
    // a WAIT lasting more than TIMEOUT+1 cycles ends in ERR one cycle later.
    function automatic vec_t predict(input vec_t v, input q4_t prev_y);
        vec_t o = v;
        for (int i = 0; i < 4; i++) o.exp_h[i] = qref($signed(v.l1[i]));
        if (v.d1 > TMO + 1) begin
            o.exp_end = 2 + TMO + 2; o.exp_err = 1'b1; o.exp_y = prev_y;
        end else if (v.d2 > TMO + 1) begin
            o.exp_end = 5 + v.d1 + TMO + 2; o.exp_err = 1'b1; o.exp_y = prev_y;
        end else begin
            o.exp_end = 6 + v.d1 + v.d2; o.exp_err = 1'b0; o.exp_y = v.l2;
        end
        return o;
    endfunction

    function automatic int rnd_d();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(15, 18));
        return int'($urandom_range(1, 4));
    endfunction

    function automatic int rnd_acc();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 4095)) - 1024;
        return int'($urandom_range(0, 131071)) - 65536;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int i = 0; i < 4; i++) begin
            v.x[i]  = int'($urandom_range(0, 127)) - 64;
            v.l1[i] = rnd_acc();
            v.l2[i] = rnd_acc();
        end
        v.d1 = rnd_d(); v.d2 = rnd_d();
        v.stray = int'($urandom_range(0, 2));
        v.rstc = 0;
        v.smask = $urandom() & 32'hFFFF_FFFE;
        v.exp_end = 0; v.exp_err = 1'b0; v.exp_h = '0; v.exp_y = '0;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        int sched = -1;
        int nis = 0;
        int nrd = 0;
        int endc = 0;
        int exp_n;
        logic errs = 1'b0, err1 = 1'b1, xok = 1'b1, bok = 1'b1, sok = 1'b1, bend = 1'b0;
        q4_t hs = '0;
        q4_t ys;
        @(negedge clk);
        rst = 1'b0; mac_ready_drv(1'b0, v.l1);
        start = 1'b1;
        x0 = v.x[0][IN-1:0]; x1 = v.x[1][IN-1:0]; x2 = v.x[2][IN-1:0]; x3 = v.x[3][IN-1:0];
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            if (c == 1) err1 = err;
            if (mif.w_rd_en) begin
                nrd++;
                if (mif.w_sel != (nrd == 2)) sok = 1'b0;
            end
            if (mif.mac_in_ready) begin
                nis++;
                if (mif.w_sel != (nis == 2)) sok = 1'b0;
                sched = c + ((nis == 1) ? v.d1 : v.d2);
                if (nis == 2) begin
                    hs[0] = 32'(mif.mac_x0); hs[1] = 32'(mif.mac_x1);
                    hs[2] = 32'(mif.mac_x2); hs[3] = 32'(mif.mac_x3);
                end
            end
            if (busy && !mif.w_sel &&
                (mif.mac_x0 != v.x[0][IN-1:0] || mif.mac_x1 != v.x[1][IN-1:0] ||
                 mif.mac_x2 != v.x[2][IN-1:0] || mif.mac_x3 != v.x[3][IN-1:0])) xok = 1'b0;
            if (done || err) begin
                endc = c; errs = err; bend = busy;
                break;
            end
            if (!busy && (v.rstc == 0 || c <= v.rstc)) bok = 1'b0;
            start = (c < 32) ? v.smask[c] : 1'b0;
            if (start) begin
                x0 = ~v.x[0][IN-1:0]; x1 = ~v.x[1][IN-1:0];
                x2 = ~v.x[2][IN-1:0]; x3 = ~v.x[3][IN-1:0];
            end
            rst = (c == v.rstc);
            if (c == sched) mac_ready_drv(1'b1, (nis == 1) ? v.l1 : v.l2);
            else mac_ready_drv(c == v.stray, junk4());
        end
        start = 1'b0; rst = 1'b0; mac_ready_drv(1'b0, junk4());
        ys[0] = 32'(y0); ys[1] = 32'(y1); ys[2] = 32'(y2); ys[3] = 32'(y3);
        exp_n = (v.d1 > TMO + 1) ? 1 : 2;
        chk({nm, ".end_cycle"}, endc, v.exp_end);
        chk({nm, ".err_seen"}, errs, v.exp_err);
        chk({nm, ".err_after_start"}, err1, 0);
        chk({nm, ".busy_at_end"}, bend, (v.exp_end != 0 && !v.exp_err) ? 1 : 0);
        chk({nm, ".busy_during_run"}, bok, 1);
        chk({nm, ".x_held"}, xok, 1);
        chk({nm, ".w_sel_order"}, sok, 1);
        chk({nm, ".rd_pulses"}, nrd, exp_n);
        chk({nm, ".issue_pulses"}, nis, exp_n);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.y%0d", nm, i), $signed(ys[i]), $signed(v.exp_y[i]));
            if (exp_n == 2)
                chk($sformatf("%s.h%0d", nm, i), $signed(hs[i]), $signed(v.exp_h[i]));
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk({nm, ".post_done"}, done, 0);
            chk({nm, ".post_busy"}, busy, 0);
        end
        chk({nm, ".post_err"}, err, v.exp_err);
        model_y = v.exp_y;
    endtask

    function automatic q4_t junk4();
        q4_t r;
        for (int i = 0; i < 4; i++) r[i] = int'($urandom_range(0, 131071)) - 65536;
        return r;
    endfunction

    task automatic mac_ready_drv(input logic rdy, input q4_t o);
        mif.mac_ready = rdy;
        mif.mac_out0 = o[0][OUT-1:0]; mif.mac_out1 = o[1][OUT-1:0];
        mif.mac_out2 = o[2][OUT-1:0]; mif.mac_out3 = o[3][OUT-1:0];
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = mkv(mk4(10, 20, -5, 3), mk4(100, -50, 4000, 31), mk4(7, -9, 0, 1234),
                     1, 1, 0, 0, 0, 8, 1'b0, mk4(3, 0, 63, 0), mk4(7, -9, 0, 1234));
        tbl[1] = mkv(mk4(1, 2, 3, 4), mk4(2047, 2016, -1, 0), mk4(-65536, 65535, 5, -5),
                     1, 1, 0, 0, 0, 8, 1'b0, mk4(63, 63, 0, 0), mk4(-65536, 65535, 5, -5));
        tbl[2] = mkv(mk4(-64, 63, 0, -1), mk4(32, 64, -32, 1000), mk4(1, 2, 3, 4),
                     16, 1, 0, 0, 0, 23, 1'b0, mk4(1, 2, 0, 31), mk4(1, 2, 3, 4));
        tbl[3] = mkv(mk4(9, 8, 7, 6), mk4(65535, -65536, 95, 96), mk4(-1, -2, -3, -4),
                     1, 16, 0, 0, 0, 23, 1'b0, mk4(63, 0, 2, 3), mk4(-1, -2, -3, -4));
        tbl[4] = mkv(mk4(5, 5, 5, 5), mk4(1, 1, 1, 1), mk4(2, 2, 2, 2),
                     200, 1, 0, 0, 0, 19, 1'b1, mk4(0, 0, 0, 0), mk4(-1, -2, -3, -4));
        tbl[5] = mkv(mk4(7, 7, 7, 7), mk4(320, -320, 640, 33), mk4(11, 22, 33, 44),
                     1, 1, 0, 0, 0, 8, 1'b0, mk4(10, 0, 20, 1), mk4(11, 22, 33, 44));
        tbl[6] = mkv(mk4(1, 1, 1, 1), mk4(64, 64, 64, 64), mk4(9, 8, 7, 6),
                     1, 1, 5, 0, 32'h84, 8, 1'b0, mk4(2, 2, 2, 2), mk4(9, 8, 7, 6));
        tbl[7] = mkv(mk4(2, 3, 4, 5), mk4(32, 32, 32, 32), mk4(100, 100, 100, 100),
                     1, 1, 8, 7, 0, 0, 1'b0, mk4(1, 1, 1, 1), mk4(0, 0, 0, 0));

        // Reset must override a pending start and mac_ready
        rst = 1'b1; start = 1'b1; x0 = 7'sd5; x1 = 7'sd5; x2 = 7'sd5; x3 = 7'sd5;
        mac_ready_drv(1'b1, junk4());
        repeat (3) @(negedge clk);
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.err", err, 0);
        chk("reset.w_rd_en", mif.w_rd_en, 0);
        chk("reset.w_sel", mif.w_sel, 0);
        chk("reset.mac_in_ready", mif.mac_in_ready, 0);
        chk("reset.y", {y0, y1, y2, y3}, 0);
        chk("reset.mac_x", {mif.mac_x0, mif.mac_x1, mif.mac_x2, mif.mac_x3}, 0);
        rst = 1'b0; start = 1'b0; mac_ready_drv(1'b0, junk4());
        @(negedge clk);
        chk("reset.idle_after", busy, 0);
        model_y = '0;

        for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("vec%0d", i));

        for (int r = 0; r < 40; r++) apply(predict(rnd_vec(), model_y), $sformatf("rand%0d", r));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dnn_layer_sched.md
DNN_LAYER_SCHED -- requirements
Module: dnn_layer_sched

Interface
REQ-001 Parameter IN_SIZE, default 7: bit width of activations and of MAC operands.
REQ-002 Parameter OUT_SIZE, default 17: bit width of MAC accumulations.
REQ-003 Parameter SHIFT, default 5: right-shift applied when requantizing layer-1 results.
REQ-004 Parameter TIMEOUT, default 15: maximum number of cycles in a WAIT state before an error is flagged.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: request to run one 2-layer inference; sampled only in IDLE and ERR.
REQ-008 Ports x0..x3, input, IN_SIZE signed each: network inputs; latched when start is accepted.
REQ-009 Port w_rd_en, output, 1: read strobe to the weight ROM; ROM data is valid at the MAC one cycle later.
REQ-010 Port w_sel, output, 1: weight bank select; 0 = layer-1 bank, 1 = layer-2 bank.
REQ-011 Ports mac_x0..mac_x3, output, IN_SIZE signed each: operands driven to the shared 4x4 MAC.
REQ-012 Port mac_in_ready, output, 1: one-cycle pulse to the MAC meaning operands and weights are valid.
REQ-013 Port mac_ready, input, 1: pulse from the MAC meaning its results are valid.
REQ-014 Ports mac_out0..mac_out3, input, OUT_SIZE signed each: MAC accumulations.
REQ-015 Ports y0..y3, output, OUT_SIZE signed each: layer-2 accumulations, with no ReLU applied.
REQ-016 Port busy, output, 1: high in every state except IDLE and ERR.
REQ-017 Port done, output, 1: one-cycle pulse when y0..y3 are updated.
REQ-018 Port err, output, 1: high while in ERR.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH1, ISSUE1, WAIT1, QUANT, FETCH2, ISSUE2, WAIT2, DONE and ERR.
REQ-020 IDLE with start=1 SHALL latch x0..x3 into h0..h3 and go to FETCH1; otherwise it stays in IDLE.
REQ-021 FETCH1 and FETCH2 SHALL assert w_rd_en for exactly one cycle, with w_sel=0 in FETCH1 and w_sel=1 in FETCH2, then go to ISSUE1 or ISSUE2 respectively.
REQ-022 ISSUE1 and ISSUE2 SHALL assert mac_in_ready for exactly one cycle, hold w_sel unchanged, and go to WAIT1 or WAIT2 respectively.
REQ-023 mac_x0..mac_x3 SHALL always equal h0..h3.
REQ-024 WAIT1 and WAIT2 SHALL increment a wait counter each cycle that mac_ready=0, and SHALL leave the state on mac_ready=1.
REQ-025 WAIT1 SHALL exit to QUANT; WAIT2 SHALL capture mac_out0..3 into y0..3 and exit to DONE.
REQ-026 In a WAIT state, if the wait counter equals TIMEOUT and mac_ready=0, the FSM SHALL go to ERR; if mac_ready=1 in that same cycle, mac_ready wins.
REQ-027 The wait counter SHALL clear on entry to each WAIT state.
REQ-028 In QUANT, each h SHALL be set from the corresponding captured layer-1 result: 0 if the result is negative, otherwise (result >>> SHIFT) clamped to 2^(IN_SIZE-1)-1.
REQ-029 Layer-1 mac_out SHALL be captured on the WAIT1 exit edge, and QUANT SHALL use the captured values.
REQ-030 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-031 ERR SHALL hold err=1 and hold y0..y3; start=1 in ERR SHALL clear err, latch x0..x3 and go to FETCH1.
REQ-032 start SHALL be ignored while busy=1.
REQ-033 mac_ready SHALL be ignored outside WAIT1 and WAIT2.
REQ-034 With a MAC whose mac_ready follows mac_in_ready by one cycle, done SHALL be high in the 8th cycle after the cycle in which start was sampled.
REQ-035 All arithmetic SHALL be signed two's complement, with no truncation other than the QUANT clamp.

Reset
REQ-036 While rst=1 on a clock edge, the FSM SHALL go to IDLE, overriding start and mac_ready.
REQ-037 On reset, y0..y3, h0..h3 and the wait counter SHALL clear to 0.
REQ-038 On reset, w_rd_en, w_sel, mac_in_ready, busy, done and err SHALL clear to 0.
REQ-039 Reset asserted mid-inference SHALL abort the inference; a mac_ready arriving after reset SHALL be ignored.

Verification
REQ-040 Nominal run (1-cycle MAC model): start with x=(10,20,-5,3); layer-1 MAC returns (100,-50,4000,31).
  -> QUANT sets h=(3,0,63,0); mac_x=(3,0,63,0) during ISSUE2.
  -> Layer-2 return (7,-9,0,1234) appears on y; done is high exactly 8 cycles after start.
REQ-041 Timeout: the MAC never asserts mac_ready in WAIT1.
  -> err rises after TIMEOUT+1 WAIT cycles; busy=0; y is unchanged.
  -> A following start clears err and the run completes.
REQ-042 Boundary: mac_ready arrives in the same cycle the counter equals TIMEOUT -> the FSM proceeds to QUANT with err=0.
REQ-043 Busy/idle filtering: start pulsed in ISSUE1 and WAIT2 -> no restart and x not relatched.
  -> A stray mac_ready in FETCH2 is ignored; exactly one done pulse per accepted start.
REQ-044 Reset mid-operation: rst in WAIT2 with mac_ready=1 on the same edge -> IDLE, y=0, done never pulses.
REQ-045 Clamp limits: layer-1 results (2047,2016,-1,0) -> h=(63,63,0,0).
